// File: rtl/hack_data_memory.sv
// Hack data memory (RAM, screen, keyboard) with a handshaked screen scanout port and frame dirty flag.
// inM is combinational; scan_data lands one cycle after an IDLE request, acks at most every 2 cycles; CPU never stalls.
module hack_data_memory #(
    parameter int          RAM_WORDS    = 16384,
    parameter logic [15:0] SCREEN_BASE  = 16'h4000,
    parameter int          SCREEN_WORDS = 8192,
    parameter logic [15:0] KBD_ADDR     = 16'h6000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic [15:0] key_code,
    input  logic        key_valid,
    input  logic        key_release,
    input  logic        scan_req,
    input  logic [12:0] scan_addr,
    output logic        scan_ack,
    output logic [15:0] scan_data,
    input  logic        frame_start,
    output logic        screen_dirty
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);
    localparam logic [15:0] SCREEN_END = 16'(int'(SCREEN_BASE) + SCREEN_WORDS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic [15:0] ram_mem [RAM_WORDS];
    logic [15:0] scr_mem [SCREEN_WORDS];

    logic [0:0]  state_q, state_d;
    logic [15:0] scan_data_q, scan_data_d;
    logic        dirty_q, dirty_d;
    logic [15:0] kbd_q, kbd_d;

    logic [15:0]       addr16;
    logic              is_ram, is_scr, is_kbd;
    logic              ram_we, scr_we;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;

    assign addr16  = {1'b0, addressM};
    assign is_ram  = addr16 < SCREEN_BASE;
    assign is_scr  = (addr16 >= SCREEN_BASE) && (addr16 < SCREEN_END);
    assign is_kbd  = addr16 == KBD_ADDR;
    assign ram_idx = addressM[RAM_AW-1:0];
    assign scr_idx = addressM[SCR_AW-1:0];
    assign ram_we  = writeM && is_ram;
    assign scr_we  = writeM && is_scr;

    always_comb begin
        inM = '0;
        if (is_ram) begin
            inM = ram_mem[ram_idx];
        end else if (is_scr) begin
            inM = scr_mem[scr_idx];
        end else if (is_kbd) begin
            inM = kbd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= outM;
        end
        if (scr_we) begin
            scr_mem[scr_idx] <= outM;
        end
    end

    always_comb begin
        state_d     = state_q;
        scan_data_d = scan_data_q;
        case (state_q)
            ST_IDLE: begin
                if (scan_req) begin
                    // Forward a same-cycle CPU write so scanout never sees a stale word.
                    if (scr_we && (scr_idx == scan_addr)) begin
                        scan_data_d = outM;
                    end else begin
                        scan_data_d = scr_mem[scan_addr];
                    end
                    state_d = ST_ACK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dirty_d = dirty_q;
        if (scr_we) begin
            dirty_d = 1'b1;
        end else if (frame_start) begin
            dirty_d = 1'b0;
        end
    end

    always_comb begin
        kbd_d = kbd_q;
        if (key_valid) begin
            kbd_d = key_code;
        end else if (key_release) begin
            kbd_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            scan_data_q <= '0;
            dirty_q     <= 1'b0;
            kbd_q       <= '0;
        end else begin
            state_q     <= state_d;
            scan_data_q <= scan_data_d;
            dirty_q     <= dirty_d;
            kbd_q       <= kbd_d;
        end
    end

    assign scan_ack     = (state_q == ST_ACK);
    assign scan_data    = scan_data_q;
    assign screen_dirty = dirty_q;

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory stage directly downstream of the Hack CPU; consumes addressM/outM/writeM and produces inM.
- Memory map:
  - 0x0000-0x3FFF: general RAM.
  - 0x4000-0x5FFF: screen buffer.
  - 0x6000: keyboard register.
- Adds a second, handshaked read port so the display scanout logic can fetch screen words while the CPU runs.
- Tracks a per-frame dirty flag so the display can skip unchanged frames.

Parameters:
- RAM_WORDS, 16384, general RAM depth; base 0x0000.
- SCREEN_BASE, 16'h4000, first screen address.
- SCREEN_WORDS, 8192, screen buffer depth; 32 words x 256 rows.
- KBD_ADDR, 16'h6000, keyboard register address.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- reset, input, 1, asynchronous active-high reset.
- addressM, input, 15, CPU data address.
- outM, input, 16, CPU write data.
- writeM, input, 1, CPU write enable.
- inM, output, 16, CPU read data; combinational from addressM.
- key_code, input, 16, scan code from keyboard decoder.
- key_valid, input, 1, one-cycle strobe; latch key_code.
- key_release, input, 1, one-cycle strobe; clear keyboard register.
- scan_req, input, 1, scanout read request; held until ack.
- scan_addr, input, 13, screen word offset; stable while scan_req is high.
- scan_ack, output, 1, one-cycle pulse; scan_data valid in the same cycle.
- scan_data, output, 16, registered screen word.
- frame_start, input, 1, one-cycle strobe at start of a display frame.
- screen_dirty, output, 1, high if any screen write occurred since the last frame_start.

Behaviour:
- Reset (asynchronous, active-high) drives:
  - scan_ack=0, scan_data=0, screen_dirty=0.
  - Keyboard register=0.
  - Scan FSM to IDLE.
  - RAM and screen array contents are not cleared.
- CPU read path:
  - inM is purely combinational from addressM, so it is valid in the same cycle; the CPU samples it at posedge.
  - Decode:
    - addr < 0x4000 returns RAM[addr].
    - 0x4000-0x5FFF returns SCREEN[addr-0x4000].
    - 0x6000 returns the keyboard register.
    - addr > 0x6000 returns 0.
- CPU write path:
  - When writeM=1, outM is written at posedge to RAM or screen per the same decode.
  - Writes to KBD_ADDR or addr > 0x6000 are ignored; no state changes.
  - A read of the same address in the cycle after a write returns the new value.
- Keyboard register:
  - key_valid loads key_code; key_release clears to 0.
  - If both strobes occur in the same cycle, key_valid wins.
  - The CPU cannot write this register.
- Scan FSM, two states:
  - IDLE: when scan_req=1, at posedge capture SCREEN[scan_addr] into scan_data and go to ACK.
  - ACK: scan_ack=1 for exactly one cycle; unconditionally return to IDLE.
  - Throughput is one word per 2 cycles. If scan_req stays high through ACK, the next capture happens on the following IDLE cycle using the then-current scan_addr.
  - scan_data holds its value until the next capture.
- Collision rule: if in the IDLE capture cycle the CPU writes the same screen word (writeM=1, addressM-0x4000 == scan_addr), scan_data captures outM (write-forwarding). CPU writes are never blocked or delayed.
- Dirty flag:
  - Set at posedge by any CPU write in 0x4000-0x5FFF.
  - Cleared by frame_start.
  - If a screen write and frame_start occur in the same cycle, the flag ends set: the write belongs to the new frame.
- Reset asserted mid-transaction: scan_ack drops immediately and the FSM returns to IDLE. The requester must hold or re-raise scan_req after reset deasserts.
- Address arithmetic:
  - Screen offset is addressM[12:0] when addressM[14:13]=2'b10.
  - No wrap-around: scan_addr is 13 bits and covers exactly SCREEN_WORDS.

Test Plan:
1. RAM write/read: write 0x1234 to addr 0x0010 -> the next cycle with addressM=0x0010 shows inM=0x1234; addr 0x6001 write of 0xFFFF -> inM reads 0 at 0x6001.
2. Keyboard: key_valid with key_code=0x0083 -> inM=0x0083 at 0x6000. key_release -> 0. key_valid and key_release together with code 0x0041 -> 0x0041. CPU write to 0x6000 leaves the register unchanged.
3. Scanout handshake: preload SCREEN[5]=0xA5A5, hold scan_req=1 with scan_addr=5 -> scan_ack pulses one cycle later with scan_data=0xA5A5. With scan_req held high, acks repeat every 2 cycles.
4. Collision: SCREEN[7]=0x0000. Same cycle: CPU writes 0xBEEF to 0x4007 and the scan FSM captures addr 7 -> scan_data=0xBEEF at ack; a subsequent scan of 7 also returns 0xBEEF.
5. Dirty flag: a write to 0x4100 sets screen_dirty. frame_start clears it. frame_start coincident with a write to 0x5FFF leaves screen_dirty=1. A RAM write alone never sets it.
6. Reset mid-operation: assert reset during the ACK cycle -> scan_ack=0, scan_data=0, screen_dirty=0, keyboard=0 immediately, without waiting for a clock. A RAM word written before reset still reads back unchanged.
